// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter sequencer.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int DIV_DEFAULT = 50000000;
    localparam int DEB_DEFAULT = 500000;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability debouncer and
// a single-cycle press pulse on each debounced falling edge.
module key_debounce
    import counter_pkg::*;
#(
    parameter int DEB = DEB_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;

    logic          s1;
    logic          s2;
    logic          lvl;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            lvl   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            // lvl flips only after DEB consecutive samples disagree with it
            if (s2 != lvl) begin
                if (cnt == CW'(DEB - 1)) begin
                    lvl   <= s2;
                    cnt   <= '0;
                    press <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Key-driven sequencer issuing load/step strobes to an external counter,
// with a free-running RUN mode, auto-stop compare and a saturating step tally.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT,
    parameter int DEB = DEB_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_step_n,
    input  logic       key_load_n,
    input  logic       key_run_n,
    input  logic [2:0] load_val,
    input  logic       stop_en,
    input  logic [2:0] stop_val,
    input  logic [2:0] cnt_q,
    output logic       cnt_load,
    output logic [2:0] load_data,
    output logic       cnt_step,
    output logic [1:0] state,
    output logic [7:0] steps
);

    localparam int PW = $clog2(DIV);

    state_t        cur;
    state_t        nxt;
    logic          ev_step;
    logic          ev_load;
    logic          ev_run;
    logic [PW-1:0] pre;
    logic          tick;
    logic          stop_hit;
    logic          load_nxt;
    logic          step_nxt;

    key_debounce #(.DEB(DEB)) u_step (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (key_step_n),
        .press (ev_step)
    );

    key_debounce #(.DEB(DEB)) u_load (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (key_load_n),
        .press (ev_load)
    );

    key_debounce #(.DEB(DEB)) u_run (
        .clk   (CLOCK_50),
        .reset (reset),
        .key_n (key_run_n),
        .press (ev_run)
    );

    assign tick     = (cur == RUN) && (pre == PW'(DIV - 1));
    assign stop_hit = stop_en && (cnt_q == stop_val);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) cur <= IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        if (ev_load) begin
            nxt = IDLE;
        end else if (ev_run) begin
            unique case (cur)
                IDLE:    nxt = RUN;
                RUN:     nxt = PAUSE;
                PAUSE:   nxt = RUN;
                default: nxt = cur;
            endcase
        end else if (tick && stop_hit) begin
            nxt = DONE;
        end
    end

    // Priority: load > run > tick/step; a losing event is simply dropped.
    always_comb begin
        load_nxt = ev_load;
        step_nxt = 1'b0;
        if (!ev_load && !ev_run) begin
            if (tick)
                step_nxt = ~stop_hit;
            else if (ev_step && (cur == IDLE || cur == PAUSE))
                step_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            pre       <= '0;
            cnt_load  <= 1'b0;
            cnt_step  <= 1'b0;
            load_data <= '0;
            steps     <= '0;
        end else begin
            pre      <= (cur == RUN && !tick) ? pre + 1'b1 : '0;
            cnt_load <= load_nxt;
            cnt_step <= step_nxt;
            if (ev_load)
                load_data <= load_val;
            if (ev_load)
                steps <= '0;
            else if (step_nxt && steps != 8'hFF)
                steps <= steps + 1'b1;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed key-press table, corner sequences
// and random key traffic against a cycle-level behavioural model.
module tb_counter_sequencer;

    localparam int DIV = 4;
    localparam int DEB = 2;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [2:0] keys_n;
    logic [2:0] load_val;
    logic       stop_en;
    logic [2:0] stop_val;
    logic [2:0] cnt_q;
    logic       cnt_load;
    logic [2:0] load_data;
    logic       cnt_step;
    logic [1:0] state;
    logic [7:0] steps;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(.DIV(DIV), .DEB(DEB)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_step_n (keys_n[0]),
        .key_load_n (keys_n[2]),
        .key_run_n  (keys_n[1]),
        .load_val   (load_val),
        .stop_en    (stop_en),
        .stop_val   (stop_val),
        .cnt_q      (cnt_q),
        .cnt_load   (cnt_load),
        .load_data  (load_data),
        .cnt_step   (cnt_step),
        .state      (state),
        .steps      (steps)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference model: key index 0=step, 1=run, 2=load.
    bit hist [3][0:DEB];
    bit stbl [3];
    bit mpress [3];
    int m_state;
    int m_age;
    int m_steps;
    int m_ldata;
    bit m_load;
    bit m_step;

    task automatic model_step();
        bit ev [3];
        bit np [3];
        bit all0;
        bit all1;
        bit tick;
        int prev;
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j <= DEB; j++) hist[k][j] = 1'b1;
                stbl[k]   = 1'b1;
                mpress[k] = 1'b0;
            end
            m_state = S_IDLE;
            m_age   = 0;
            m_steps = 0;
            m_ldata = 0;
            m_load  = 1'b0;
            m_step  = 1'b0;
            return;
        end
        ev = mpress;
        for (int k = 0; k < 3; k++) begin
            all0 = 1'b1;
            all1 = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                if (hist[k][j]) all0 = 1'b0;
                else            all1 = 1'b0;
            end
            np[k] = all0 && stbl[k];
            if (all0)      stbl[k] = 1'b0;
            else if (all1) stbl[k] = 1'b1;
            for (int j = DEB; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = keys_n[k];
        end
        mpress = np;
        tick   = (m_state == S_RUN) && ((m_age % DIV) == DIV - 1);
        prev   = m_state;
        m_load = 1'b0;
        m_step = 1'b0;
        if (ev[2]) begin
            m_state = S_IDLE;
            m_load  = 1'b1;
            m_ldata = int'(load_val);
            m_steps = 0;
        end else if (ev[1] && m_state != S_DONE) begin
            m_state = (m_state == S_RUN) ? S_PAUSE : S_RUN;
        end else if (tick) begin
            if (stop_en && cnt_q == stop_val) m_state = S_DONE;
            else                              m_step  = 1'b1;
        end else if (ev[0] && (m_state == S_IDLE || m_state == S_PAUSE)) begin
            m_step = 1'b1;
        end
        if (m_step && m_steps < 255) m_steps++;
        m_age = (m_state == S_RUN && prev == S_RUN) ? m_age + 1 : 0;
    endtask

    task automatic check_cycle();
        logic [14:0] got;
        logic [14:0] exp;
        got = {state, cnt_load, cnt_step, load_data, steps};
        exp = {2'(m_state), m_load, m_step, 3'(m_ldata), 8'(m_steps)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle t=%0t got st=%0d ld=%0b sp=%0b data=%0d steps=%0d want st=%0d ld=%0b sp=%0b data=%0d steps=%0d",
                     $time, state, cnt_load, cnt_step, load_data, steps,
                     m_state, m_load, m_step, m_ldata, m_steps);
        end
        checks++;
        if (cnt_load === 1'b1 && cnt_step === 1'b1) begin
            errors++;
            $display("FAIL strobe_excl t=%0t got load=1 step=1 want not both", $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        check_cycle();
    endtask

    task automatic expect_out(input string name, input logic [1:0] st,
                              input logic [7:0] sp, input logic [2:0] ld);
        checks++;
        if (state !== st || steps !== sp || load_data !== ld) begin
            errors++;
            $display("FAIL %s got st=%0d steps=%0d data=%0d want st=%0d steps=%0d data=%0d",
                     name, state, steps, load_data, st, sp, ld);
        end
    endtask

    typedef struct {
        logic [2:0] key;
        int         hold;
        int         gap;
        logic [2:0] lval;
        logic       sen;
        logic [2:0] sval;
        logic [2:0] q;
        logic [1:0] st;
        logic [7:0] sp;
        logic [2:0] ld;
    } vec_t;

    vec_t vt [11];
    int   kc [3];

    initial begin
        vt[0]  = '{3'b100, 4, 6,  3'd5, 1'b0, 3'd0, 3'd0, 2'd0, 8'd0, 3'd5};
        vt[1]  = '{3'b010, 4, 10, 3'd5, 1'b0, 3'd0, 3'd0, 2'd1, 8'd2, 3'd5};
        vt[2]  = '{3'b010, 4, 6,  3'd5, 1'b0, 3'd0, 3'd0, 2'd2, 8'd3, 3'd5};
        vt[3]  = '{3'b001, 4, 6,  3'd5, 1'b0, 3'd0, 3'd0, 2'd2, 8'd4, 3'd5};
        vt[4]  = '{3'b001, 4, 6,  3'd5, 1'b0, 3'd0, 3'd0, 2'd2, 8'd5, 3'd5};
        vt[5]  = '{3'b001, 1, 6,  3'd5, 1'b0, 3'd0, 3'd0, 2'd2, 8'd5, 3'd5};
        vt[6]  = '{3'b010, 4, 6,  3'd5, 1'b1, 3'd2, 3'd2, 2'd3, 8'd5, 3'd5};
        vt[7]  = '{3'b010, 4, 6,  3'd5, 1'b1, 3'd2, 3'd2, 2'd3, 8'd5, 3'd5};
        vt[8]  = '{3'b100, 4, 6,  3'd3, 1'b0, 3'd0, 3'd0, 2'd0, 8'd0, 3'd3};
        vt[9]  = '{3'b110, 4, 6,  3'd6, 1'b0, 3'd0, 3'd0, 2'd0, 8'd0, 3'd6};
        vt[10] = '{3'b010, 4, 6,  3'd6, 1'b0, 3'd0, 3'd0, 2'd1, 8'd1, 3'd6};

        reset    = 1'b0;
        keys_n   = 3'b111;
        load_val = 3'd0;
        stop_en  = 1'b0;
        stop_val = 3'd0;
        cnt_q    = 3'd0;
        @(negedge CLOCK_50);
        cyc();
        cyc();
        expect_out("reset_state", 2'd0, 8'd0, 3'd0);
        reset = 1'b1;
        cyc();

        for (int i = 0; i < 11; i++) begin
            load_val = vt[i].lval;
            stop_en  = vt[i].sen;
            stop_val = vt[i].sval;
            cnt_q    = vt[i].q;
            keys_n   = ~vt[i].key;
            repeat (vt[i].hold) cyc();
            keys_n = 3'b111;
            repeat (vt[i].gap) cyc();
            expect_out($sformatf("vec%0d", i), vt[i].st, vt[i].sp, vt[i].ld);
        end

        // Long RUN: the tally must saturate.
        repeat (1100) cyc();
        expect_out("saturate", 2'd1, 8'd255, 3'd6);

        // One-cycle reset in the middle of RUN.
        reset = 1'b0;
        cyc();
        checks++;
        if (cnt_load !== 1'b0 || cnt_step !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobe got load=%0b step=%0b want 0 0", cnt_load, cnt_step);
        end
        expect_out("reset_mid_run", 2'd0, 8'd0, 3'd0);
        reset = 1'b1;
        repeat (8) cyc();
        expect_out("after_reset", 2'd0, 8'd0, 3'd0);

        // Run key held low across reset release acts as a fresh press.
        keys_n = 3'b101;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        repeat (2) cyc();
        expect_out("held_key_early", 2'd0, 8'd0, 3'd0);
        repeat (6) cyc();
        expect_out("held_key_press", 2'd1, 8'd0, 3'd0);
        keys_n = 3'b111;
        repeat (6) cyc();

        for (int k = 0; k < 3; k++) kc[k] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (kc[k] == 0) begin
                    keys_n[k] = 1'($urandom_range(0, 1));
                    kc[k] = $urandom_range(1, 8);
                end
                kc[k]--;
            end
            load_val = 3'($urandom_range(0, 7));
            cnt_q    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) stop_en = ~stop_en;
            if ($urandom_range(0, 9) == 0) stop_val = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter DIV, default 50000000, sets the RUN-mode step period in CLOCK_50 cycles (minimum 2).
REQ-002 Parameter DEB, default 500000, sets the key debounce stability window in cycles (minimum 1).
REQ-003 CLOCK_50  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 key_step_n  in  1  raw push button, active-low, asynchronous to CLOCK_50.
REQ-006 key_load_n  in  1  raw push button, active-low, asynchronous.
REQ-007 key_run_n  in  1  raw push button, active-low, asynchronous.
REQ-008 load_val  in  3  value to load into the counter datapath.
REQ-009 stop_en  in  1  enables the auto-stop compare in RUN.
REQ-010 stop_val  in  3  auto-stop compare value.
REQ-011 cnt_q  in  3  current counter datapath value.
REQ-012 cnt_load  out  1  one-cycle load strobe to the datapath.
REQ-013 load_data  out  3  value accompanying cnt_load.
REQ-014 cnt_step  out  1  one-cycle advance strobe to the datapath.
REQ-015 state  out  2  current FSM state.
REQ-016 steps  out  8  steps issued since last load, saturating; feeds the BCD display path.

Function
REQ-017 Each key passes a 2-flop synchroniser, then a debouncer: one press event fires when the synchronised level has been low for DEB consecutive cycles; re-arm only after DEB consecutive high cycles.
REQ-018 A held key produces exactly one press event; a low glitch shorter than DEB cycles produces none.
REQ-019 FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11.
REQ-020 Load event in any state: next cycle cnt_load=1, load_data=load_val registered at the event, steps=0, state=IDLE.
REQ-021 Run event: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; ignored in DONE.
REQ-022 Step event in IDLE or PAUSE: next cycle cnt_step=1 for one cycle; ignored in RUN and DONE.
REQ-023 Simultaneous events in one cycle: load wins over run and step; run wins over step; losers are discarded.
REQ-024 Prescaler counts 0..DIV-1 only in RUN; cleared to 0 in any other state; tick when it equals DIV-1, then wraps to 0.
REQ-025 First RUN tick occurs DIV cycles after entry into RUN.
REQ-026 On a RUN tick: if stop_en=1 and cnt_q==stop_val, state->DONE and no step is issued; otherwise cnt_step=1 next cycle.
REQ-027 steps increments on every cycle with cnt_step=1 and holds at 255.
REQ-028 cnt_load and cnt_step are never both 1 in the same cycle.
REQ-029 All outputs are registered; no combinational input-to-output path.

Reset
REQ-030 reset=0 at a clock edge forces state=IDLE, cnt_load=0, load_data=0, cnt_step=0, steps=0, prescaler=0, all synchroniser and debouncer registers to released (high) state.
REQ-031 A key held low across reset deassertion is treated as a fresh press only after DEB stable low cycles.
REQ-032 Reset mid-RUN discards any pending tick or step; no strobe issues in the cycle after reset.

Structure
REQ-033 State encodings and DIV/DEB defaults live in a shared package, counter_pkg.
REQ-034 One sub-module, key_debounce (synchroniser + debouncer + press pulse), instantiated three times.

Verification (DIV=4, DEB=2)
REQ-035 load_val=3'd5, press key_load_n -> exactly one cnt_load pulse with load_data=5, steps=0, state=IDLE.
REQ-036 Press key_run_n from IDLE -> state=RUN; cnt_step pulses every 4 cycles; after 3 pulses steps=3; second run press -> state=PAUSE, pulses stop.
REQ-037 In PAUSE, key_step_n pressed twice -> two single-cycle cnt_step pulses, steps +2; 1-cycle low glitch -> no pulse.
REQ-038 stop_en=1, stop_val=3'd2, RUN with cnt_q driven to 2 at a tick -> state=DONE, no cnt_step; run press ignored; load press -> IDLE.
REQ-039 Load and run keys released into press on same cycle -> only cnt_load, state=IDLE; 300 RUN steps -> steps holds 255.
REQ-040 reset=0 for one cycle mid-RUN -> all outputs zero next cycle, state=IDLE, no stray strobe.
